// File: rtl/xgmii_rx_frame_checker.sv
// Purpose: passive monitor on the 64-bit XGMII receive bus; parses Start/Data/Terminate/Error per lane, reports per-frame length/status and saturating counters.
// Latency: frame_valid/frame_good/frame_len are registered one cycle after the closing word; in_frame follows the FSM state register.
// Backpressure: none; every word is sampled and the bus is never stalled.
// Optional payload pattern check: define XGMII_CHK_PATTERN_EN to add the sticky pattern_error output.
module xgmii_rx_frame_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = (DATA_WIDTH/8),
    parameter int MAX_LEN    = 16383
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic [DATA_WIDTH-1:0] xgmii_rxd,
    input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
    input  logic                  clear,
    output logic                  in_frame,
    output logic                  frame_valid,
    output logic                  frame_good,
    output logic [15:0]           frame_len,
    output logic [31:0]           frame_count,
    output logic [15:0]           error_count,
    output logic                  seq_error
`ifdef XGMII_CHK_PATTERN_EN
    ,
    output logic                  pattern_error
`endif
);

    localparam logic [7:0]  C_START   = 8'hFB;
    localparam logic [7:0]  C_TERM    = 8'hFD;
    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    typedef enum logic {S_IDLE, S_DATA} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  lane_byte [8];
    logic [2:0]  first_k;
    logic        all_data;
    logic        start_l0;
    logic        start_l4;
    logic        term_ok;
    logic [3:0]  add_len;
    logic [16:0] sum_w;
    logic        sat_hit;
    logic [15:0] acc_sum;
    logic        bad_len;
    logic [15:0] acc_q;
    logic        sat_q;
    logic        pat_mis;
    logic        pat_bad_q;
    logic        open_now;
    logic        close_now;
    logic        close_good;
    logic        seq_hit;

    // Split the data bus into per-lane bytes (lane 0 = bits [7:0]).
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lane_byte[i] = xgmii_rxd[8*i +: 8];
        end
    end

    // Word decode: first control lane, start detection, terminate legality and length arithmetic.
    always_comb begin
        first_k = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (xgmii_rxc[i]) begin
                first_k = 3'(i);
            end
        end
        all_data = (xgmii_rxc == '0);
        start_l0 = (xgmii_rxc == 8'h01) && (lane_byte[0] == C_START);
        start_l4 = (xgmii_rxc == 8'h1F) && (lane_byte[4] == C_START);
        // A good Terminate needs FD in the first control lane and control on every lane above it.
        term_ok  = (lane_byte[first_k] == C_TERM) &&
                   ((xgmii_rxc >> first_k) == (8'hFF >> first_k));
        add_len  = all_data ? 4'd8 : {1'b0, first_k};
        sum_w    = {1'b0, acc_q} + {13'd0, add_len};
        sat_hit  = (sum_w >= 17'h0FFFF);
        acc_sum  = sat_hit ? 16'hFFFF : sum_w[15:0];
        bad_len  = (sum_w > MAX_LEN_W);
    end

`ifdef XGMII_CHK_PATTERN_EN
    // Payload byte n sits at frame index n+7; the frame index of lane j is acc_q + j.
    always_comb begin
        pat_mis = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if ((state_q == S_DATA) && (4'(j) < add_len) &&
                (({1'b0, acc_q} + 17'(j)) >= 17'd7) &&
                (lane_byte[j] != 8'(acc_q[7:0] + 8'(j) - 8'd7))) begin
                pat_mis = 1'b1;
            end
        end
    end

    // Per-frame pattern flag (forces a bad close) and the sticky pattern_error output.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            pat_bad_q     <= 1'b0;
            pattern_error <= 1'b0;
        end else begin
            if (open_now) begin
                pat_bad_q <= 1'b0;
            end else if (pat_mis) begin
                pat_bad_q <= 1'b1;
            end
            if (clear) begin
                pattern_error <= 1'b0;
            end else if (pat_mis) begin
                pattern_error <= 1'b1;
            end
        end
    end
`else
    assign pat_mis   = 1'b0;
    assign pat_bad_q = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a Start opens a frame; any control word in DATA closes it unless it is a lane-0 restart.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_l0 || start_l4) state_d = S_DATA;
            S_DATA:  if (!all_data && !start_l0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: frame open/close events and the status of a closing frame.
    always_comb begin
        in_frame   = (state_q == S_DATA);
        open_now   = 1'b0;
        close_now  = 1'b0;
        close_good = 1'b0;
        seq_hit    = 1'b0;
        if (state_q == S_IDLE) begin
            open_now = start_l0 || start_l4;
        end else if (!all_data) begin
            close_now  = 1'b1;
            seq_hit    = start_l0;
            open_now   = start_l0;
            close_good = term_ok && !bad_len && !sat_hit && !sat_q && !pat_bad_q && !pat_mis;
        end
    end

    // Length accumulator and the registered per-frame report.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            acc_q       <= 16'd0;
            sat_q       <= 1'b0;
            frame_valid <= 1'b0;
            frame_good  <= 1'b0;
            frame_len   <= 16'd0;
        end else begin
            frame_valid <= close_now;
            if (close_now) begin
                frame_len  <= acc_sum;
                frame_good <= close_good;
            end
            if (open_now) begin
                acc_q <= start_l4 ? 16'd3 : 16'd7;
                sat_q <= 1'b0;
            end else if ((state_q == S_DATA) && all_data) begin
                acc_q <= acc_sum;
                sat_q <= sat_q | sat_hit;
            end
        end
    end

    // Saturating good/bad counters and sticky seq_error; clear takes priority over any increment.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            frame_count <= 32'd0;
            error_count <= 16'd0;
            seq_error   <= 1'b0;
        end else if (clear) begin
            frame_count <= 32'd0;
            error_count <= 16'd0;
            seq_error   <= 1'b0;
        end else begin
            if (close_now && close_good && (frame_count != '1)) begin
                frame_count <= frame_count + 32'd1;
            end
            if (close_now && !close_good && (error_count != '1)) begin
                error_count <= error_count + 16'd1;
            end
            if (seq_hit) begin
                seq_error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/xgmii_rx_frame_checker.md
Name: xgmii_rx_frame_checker

Overview:
- Passive monitor on the 64-bit XGMII receive bus at the output of eth_phy_10g. It is the receive-side counterpart of the bench-side XGMII stimulus.
- Parses Start/Data/Terminate/Error structure per XGMII lane (lane 0 = bits [7:0]).
- Reports per-frame length and status, plus saturating frame and error counters.
- Used in loopback benches and on-chip status registers.

Parameters:
- DATA_WIDTH, 64, XGMII data width; only 64 is supported.
- CTRL_WIDTH, (DATA_WIDTH/8), XGMII control width.
- MAX_LEN, 16383, largest legal frame length in bytes; longer frames are flagged bad.

Ports:
- rx_clk  in  1  clock; all logic on rising edge.
- rx_rst  in  1  synchronous, active-high reset.
- xgmii_rxd  in  64  XGMII receive data.
- xgmii_rxc  in  8  XGMII receive control; bit i qualifies byte i.
- clear  in  1  synchronous clear of counters and sticky flags.
- in_frame  out  1  high while the FSM is in DATA.
- frame_valid  out  1  one-cycle pulse when a frame closes.
- frame_good  out  1  status of the closed frame; meaningful only with frame_valid.
- frame_len  out  16  bytes between Start and Terminate, preamble/SFD included; saturates at 16'hFFFF.
- frame_count  out  32  good frames; saturating.
- error_count  out  16  bad frames; saturating.
- seq_error  out  1  sticky; set on Start seen while in DATA.

Behaviour:
- Clock and reset: one clock, rx_clk. rx_rst is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, length accumulator 0.
- Character codes: Start = 0xFB, Terminate = 0xFD, Error = 0xFE, Idle = 0x07. A byte is a control character only when its rxc bit is 1.
- Start word (lane 0): rxc == 8'h01 and rxd[7:0] == FB. Length accumulator loads 7.
- Start word (lane 4): rxc == 8'h1F and rxd[39:32] == FB. Length accumulator loads 3.
- FSM states: IDLE, DATA.
- IDLE:
  - A Start word moves the FSM to DATA.
  - Every other word is ignored, including a stray FD.
- DATA, rxc == 0: accumulator += 8, saturating at 16'hFFFF.
- DATA, first lane k with rxc[k] == 1:
  - Good close requires byte k == FD and rxc[7:k] all ones. Accumulator += k, then close with good = 1 unless a bad condition applies.
  - Byte k == FE, any other control character, or a data byte above lane k: close with good = 0.
  - Start in lane 0 (rxc == 01, byte FB): close the current frame with good = 0, set seq_error, and immediately open a new frame with length 7. The FSM stays in DATA.
- Bad conditions: final length > MAX_LEN, or saturation reached, forces good = 0.
- Close timing:
  - frame_valid, frame_good and frame_len are registered and appear 1 cycle after the closing word is sampled.
  - frame_len and frame_good hold until the next close.
  - On a good close frame_count increments; on a bad close error_count increments. Both saturate at all-ones.
- in_frame: goes to 1 the cycle after the Start word and to 0 the cycle after the closing word. Back-to-back frames (Terminate word followed directly by a Start word) are legal.
- clear: zeroes frame_count, error_count and seq_error. It does not alter FSM state or the frame_* outputs. If clear coincides with a counter increment, clear wins and that increment is dropped.
- Reset mid-frame: the open frame is discarded with no frame_valid pulse.

Optional Feature:
- Macro: XGMII_CHK_PATTERN_EN.
- Defined:
  - Add output pattern_error (1 bit, sticky, cleared by clear/rx_rst).
  - Payload byte n (frame byte index n+7, i.e. after the SFD) must equal n mod 256.
  - Any mismatch sets pattern_error and forces frame_good = 0 for that frame.
  - Frame byte index is tracked per lane across words.
- Undefined: no pattern logic and no pattern_error port.

Test Plan:
- Lane-0 frame:
  - Stimulus: FB 55x6 D5 / 3 full data words / word with data lanes 0-3, FD in lane 4, rxc = F0.
  - Response: frame_len = 7+24+4 = 35, frame_good = 1, frame_count = 1, one frame_valid pulse.
- Lane-4 start:
  - Stimulus: idles in lanes 0-3, FB in lane 4, then 2 data words, then FD in lane 0 (rxc = FF).
  - Response: frame_len = 3+16 = 19, frame_good = 1.
- Error character:
  - Stimulus: frame whose last word has FE in lane 2 (rxc = 04).
  - Response: frame_good = 0, error_count = 1, frame_count unchanged.
- Sequence error:
  - Stimulus: Start, 1 data word, then a new Start word.
  - Response: first frame closes bad (len = 15), seq_error = 1; the second frame closes good after its FD.
- Continuous idle:
  - Stimulus: rxd = 0707070707070707, rxc = FF for 100 cycles, and a stray FD word.
  - Response: no frame_valid pulse, all counters 0.
- Clear and reset:
  - Stimulus: clear in the same cycle as a good close; separately, rx_rst mid-frame.
  - Response: frame_count = 0 after the coincident clear; no frame_valid after reset; all outputs 0.
